// File: rtl/pipelined_equivalence_checker.sv
// Exhaustive on-chip equivalence checker: sweeps every input vector into two external DUTs and compares their outputs.
// Optional build macro EQCHK_STOP_ON_FIRST_FAIL_EN: stop issuing vectors after the first mismatch seen while running.
module pipelined_equivalence_checker #(
  parameter int IN_WIDTH       = 2,
  parameter int OUT_WIDTH      = 1,
  parameter int PIPELINE_DEPTH = 2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [IN_WIDTH-1:0]  stim_out,
  output logic                 stim_valid,
  input  logic [OUT_WIDTH-1:0] test_out,
  input  logic [OUT_WIDTH-1:0] ground_truth_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_WIDTH-1:0] mismatch_count,
  output logic                 first_fail_valid,
  output logic [IN_WIDTH-1:0]  first_fail_vector
);

  localparam int IDX_W = IN_WIDTH + 1;
  localparam int DW    = (PIPELINE_DEPTH > 1) ? $clog2(PIPELINE_DEPTH) : 1;
  localparam logic [IDX_W-1:0]     IDX_END    = IDX_W'(1) << IN_WIDTH;
  localparam logic [DW-1:0]        DRAIN_LAST = DW'(PIPELINE_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DW-1:0]        drain_q, drain_d;
  logic [IN_WIDTH-1:0]  stim_q, stim_d;
  logic                 stim_valid_q, stim_valid_d;
  logic                 pass_q, pass_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ffv_q, ffv_d;
  logic [IN_WIDTH-1:0]  ffvec_q, ffvec_d;
  logic [1:0]           arm_q, arm_d;

  logic                pipe_valid_q [PIPELINE_DEPTH];
  logic                pipe_valid_d [PIPELINE_DEPTH];
  logic [IN_WIDTH-1:0] pipe_vec_q   [PIPELINE_DEPTH];
  logic [IN_WIDTH-1:0] pipe_vec_d   [PIPELINE_DEPTH];

  logic                cmp_valid;
  logic [IN_WIDTH-1:0] cmp_vec;
  logic                mismatch;
  logic                stop_now;

  // Reset asserts asynchronously; start is only accepted two clocks after release.
  always_comb arm_d = {arm_q[0], 1'b1};

  // Alignment pipe: stage PIPELINE_DEPTH-1 holds the vector whose DUT result is on the inputs now.
  always_comb begin
    pipe_valid_d[0] = stim_valid_q;
    pipe_vec_d[0]   = stim_q;
    for (int i = 1; i < PIPELINE_DEPTH; i++) begin
      pipe_valid_d[i] = pipe_valid_q[i-1];
      pipe_vec_d[i]   = pipe_vec_q[i-1];
    end
  end

  assign cmp_valid = pipe_valid_q[PIPELINE_DEPTH-1];
  assign cmp_vec   = pipe_vec_q[PIPELINE_DEPTH-1];
  assign mismatch  = cmp_valid && (test_out != ground_truth_out);

`ifdef EQCHK_STOP_ON_FIRST_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    drain_d      = drain_q;
    stim_d       = stim_q;
    stim_valid_d = stim_valid_q;
    pass_d       = pass_q;
    cnt_d        = cnt_q;
    ffv_d        = ffv_q;
    ffvec_d      = ffvec_q;

    if (mismatch) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_WIDTH'(1);
      if (!ffv_q) begin
        ffv_d   = 1'b1;
        ffvec_d = cmp_vec;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start && arm_q[1]) begin
          state_d      = RUN;
          idx_d        = IDX_W'(1);
          stim_d       = '0;
          stim_valid_d = 1'b1;
          drain_d      = '0;
          pass_d       = 1'b0;
          cnt_d        = '0;
          ffv_d        = 1'b0;
          ffvec_d      = '0;
        end
      end
      RUN: begin
        // idx_q is one ahead of stim_q; reaching 2^IN_WIDTH means the last vector is already out.
        if (idx_q == IDX_END || stop_now) begin
          state_d      = DRAIN;
          stim_valid_d = 1'b0;
          drain_d      = '0;
        end else begin
          stim_d = idx_q[IN_WIDTH-1:0];
          idx_d  = idx_q + IDX_W'(1);
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = DONE;
          pass_d  = (cnt_d == '0);
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      drain_q      <= '0;
      stim_q       <= '0;
      stim_valid_q <= 1'b0;
      pass_q       <= 1'b0;
      cnt_q        <= '0;
      ffv_q        <= 1'b0;
      ffvec_q      <= '0;
      arm_q        <= '0;
      for (int i = 0; i < PIPELINE_DEPTH; i++) begin
        pipe_valid_q[i] <= 1'b0;
        pipe_vec_q[i]   <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      drain_q      <= drain_d;
      stim_q       <= stim_d;
      stim_valid_q <= stim_valid_d;
      pass_q       <= pass_d;
      cnt_q        <= cnt_d;
      ffv_q        <= ffv_d;
      ffvec_q      <= ffvec_d;
      arm_q        <= arm_d;
      for (int i = 0; i < PIPELINE_DEPTH; i++) begin
        pipe_valid_q[i] <= pipe_valid_d[i];
        pipe_vec_q[i]   <= pipe_vec_d[i];
      end
    end
  end

  assign stim_out          = stim_q;
  assign stim_valid        = stim_valid_q;
  assign busy              = (state_q == RUN) || (state_q == DRAIN);
  assign done              = (state_q == DONE);
  assign pass              = pass_q;
  assign mismatch_count    = cnt_q;
  assign first_fail_valid  = ffv_q;
  assign first_fail_vector = ffvec_q;

endmodule

// File: tb/tb_pipelined_equivalence_checker.sv
// Bench for pipelined_equivalence_checker: two instances (2-bit/16-bit counter and 3-bit/2-bit counter) driving
// registered 2-stage AND DUT models, with a per-vector inversion mask on the ground-truth side.
module tb_pipelined_equivalence_checker;

  localparam int AW  = 2;
  localparam int BW  = 3;
  localparam int DEP = 2;
  localparam int NA  = 1 << AW;
  localparam int NB  = 1 << BW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] stim_a, ffvec_a, a_s1, a_s2;
  logic          sv_a, busy_a, done_a, pass_a, ffv_a, test_a, gt_a;
  logic [15:0]   cnt_a;
  logic [BW-1:0] stim_b, ffvec_b, b_s1, b_s2;
  logic          sv_b, busy_b, done_b, pass_b, ffv_b, test_b, gt_b;
  logic [1:0]    cnt_b;
  logic [NA-1:0] inv_a = '0;
  logic [NB-1:0] inv_b = '0;

  // External DUT pair: 2-cycle registered reduction-AND; ground truth optionally inverted per vector.
  always @(posedge clk) begin
    a_s1 <= stim_a; a_s2 <= a_s1;
    b_s1 <= stim_b; b_s2 <= b_s1;
  end
  assign test_a = &a_s2;
  assign gt_a   = (&a_s2) ^ inv_a[a_s2];
  assign test_b = &b_s2;
  assign gt_b   = (&b_s2) ^ inv_b[b_s2];

  pipelined_equivalence_checker #(.IN_WIDTH(AW), .OUT_WIDTH(1), .PIPELINE_DEPTH(DEP), .CNT_WIDTH(16)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .stim_out(stim_a), .stim_valid(sv_a),
    .test_out(test_a), .ground_truth_out(gt_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .mismatch_count(cnt_a), .first_fail_valid(ffv_a), .first_fail_vector(ffvec_a));

  pipelined_equivalence_checker #(.IN_WIDTH(BW), .OUT_WIDTH(1), .PIPELINE_DEPTH(DEP), .CNT_WIDTH(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .stim_out(stim_b), .stim_valid(sv_b),
    .test_out(test_b), .ground_truth_out(gt_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .mismatch_count(cnt_b), .first_fail_valid(ffv_b), .first_fail_vector(ffvec_b));

  int errors = 0;
  int checks = 0;
  int seq[$];
  int lat;
  int busy_n;

  // Pulses start, then records issued vectors and busy cycles until done (bounded).
  // lat counts rising edges from the start pulse until done is seen.
  task automatic do_run(input bit use_b, input int extra);
    seq.delete();
    lat = 0;
    busy_n = 0;
    @(negedge clk);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    while (lat < 300) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (use_b) start_b = (extra != 0 && lat == extra);
      else       start_a = (extra != 0 && lat == extra);
      if (use_b ? sv_b : sv_a) seq.push_back(use_b ? int'(stim_b) : int'(stim_a));
      if (use_b ? busy_b : busy_a) busy_n++;
      if (use_b ? done_b : done_a) break;
    end
    if (use_b) start_b = 1'b0; else start_a = 1'b0;
    $display("run inst=%s vectors=%0d cycles=%0d", use_b ? "b" : "a", seq.size(), lat);
  endtask

  // Reference: vectors issued, saturated mismatch total, earliest failing vector, start-to-done latency.
  task automatic model(input logic [31:0] mask, input int n, input int cmax,
                       output int m, output int cnt, output int first, output int exp_lat);
    first = -1;
    m = n;
    for (int k = 0; k < n; k++) if (mask[k] && first < 0) first = k;
`ifdef EQCHK_STOP_ON_FIRST_FAIL_EN
    if (first >= 0 && first + DEP + 1 < n) m = first + DEP + 1;
`endif
    cnt = 0;
    for (int k = 0; k < m; k++) if (mask[k]) cnt++;
    if (cnt > cmax) cnt = cmax;
    exp_lat = m + DEP + 1;
  endtask

  function automatic bit seq_ok(input int m);
    if (seq.size() != m) return 1'b0;
    for (int i = 0; i < m; i++) if (seq[i] != i) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({stim_a, sv_a, busy_a, done_a, pass_a, cnt_a, ffv_a, ffvec_a} !== '0) begin
      errors++; $display("FAIL reset_a: outputs %h required 0", {stim_a, sv_a, busy_a, done_a, pass_a, cnt_a, ffv_a, ffvec_a});
    end
    checks++;
    if ({stim_b, sv_b, busy_b, done_b, pass_b, cnt_b, ffv_b, ffvec_b} !== '0) begin
      errors++; $display("FAIL reset_b: outputs %h required 0", {stim_b, sv_b, busy_b, done_b, pass_b, cnt_b, ffv_b, ffvec_b});
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_clean_run();
    inv_a = '0;
    do_run(1'b0, 0);
    checks++; if (!seq_ok(NA)) begin errors++; $display("FAIL clean_seq: got %0d vectors required 0..%0d in order", seq.size(), NA-1); end
    checks++; if (lat != NA + DEP + 1) begin errors++; $display("FAIL clean_latency: got %0d required %0d", lat, NA + DEP + 1); end
    checks++; if (busy_n != NA + DEP) begin errors++; $display("FAIL clean_busy: got %0d cycles required %0d", busy_n, NA + DEP); end
    checks++; if (pass_a !== 1'b1) begin errors++; $display("FAIL clean_pass: got %b required 1", pass_a); end
    checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL clean_count: got %0d required 0", cnt_a); end
    checks++; if (ffv_a !== 1'b0) begin errors++; $display("FAIL clean_ffv: got %b required 0", ffv_a); end
  endtask

  task automatic test_single_fail();
    inv_a = 4'b1000;
    do_run(1'b0, 0);
    checks++; if (cnt_a !== 16'd1) begin errors++; $display("FAIL single_count: got %0d required 1", cnt_a); end
    checks++; if (ffv_a !== 1'b1) begin errors++; $display("FAIL single_ffv: got %b required 1", ffv_a); end
    checks++; if (ffvec_a !== 2'd3) begin errors++; $display("FAIL single_ffvec: got %0d required 3", ffvec_a); end
    checks++; if (pass_a !== 1'b0 || done_a !== 1'b1) begin errors++; $display("FAIL single_pass: got pass=%b done=%b required 0/1", pass_a, done_a); end
    checks++; if (lat != NA + DEP + 1) begin errors++; $display("FAIL single_latency: got %0d required %0d", lat, NA + DEP + 1); end
  endtask

  task automatic test_saturate();
    int m, cnt, first, el;
    inv_b = '1;
    model(32'hFF, NB, 3, m, cnt, first, el);
    do_run(1'b1, 0);
    checks++; if (cnt_b !== 2'd3) begin errors++; $display("FAIL sat_count: got %0d required 3", cnt_b); end
    checks++; if (ffvec_b !== 3'd0 || ffv_b !== 1'b1) begin errors++; $display("FAIL sat_ffvec: got %0d/%b required 0/1", ffvec_b, ffv_b); end
    checks++; if (pass_b !== 1'b0) begin errors++; $display("FAIL sat_pass: got %b required 0", pass_b); end
    checks++; if (lat != el) begin errors++; $display("FAIL sat_latency: got %0d required %0d", lat, el); end
  endtask

  task automatic test_stop_on_fail();
    int m, cnt, first, el;
    inv_b = 8'b0000_0010;
    model(32'h2, NB, 3, m, cnt, first, el);
    do_run(1'b1, 0);
    checks++; if (!seq_ok(m)) begin errors++; $display("FAIL stop_seq: got %0d vectors required 0..%0d in order", seq.size(), m-1); end
    checks++; if (lat != el) begin errors++; $display("FAIL stop_latency: got %0d required %0d", lat, el); end
    checks++; if (cnt_b !== 2'(cnt)) begin errors++; $display("FAIL stop_count: got %0d required %0d", cnt_b, cnt); end
    checks++; if (ffvec_b !== 3'd1) begin errors++; $display("FAIL stop_ffvec: got %0d required 1", ffvec_b); end
  endtask

  task automatic test_random();
    int m, cnt, first, el;
    logic [31:0] mask;
    for (int it = 0; it < 8; it++) begin
      mask = (it == 0) ? 32'd0 : ($urandom & $urandom);
      inv_b = mask[NB-1:0];
      model({24'd0, inv_b}, NB, 3, m, cnt, first, el);
      do_run(1'b1, 0);
      checks++; if (!seq_ok(m)) begin errors++; $display("FAIL rand_seq[%0d]: got %0d vectors required %0d", it, seq.size(), m); end
      checks++; if (lat != el) begin errors++; $display("FAIL rand_latency[%0d]: got %0d required %0d", it, lat, el); end
      checks++; if (int'(cnt_b) != cnt) begin errors++; $display("FAIL rand_count[%0d]: got %0d required %0d", it, cnt_b, cnt); end
      checks++; if (pass_b !== (first < 0)) begin errors++; $display("FAIL rand_pass[%0d]: got %b required %b", it, pass_b, first < 0); end
      checks++;
      if (ffv_b !== (first >= 0) || (first >= 0 && int'(ffvec_b) != first)) begin
        errors++; $display("FAIL rand_ffvec[%0d]: got %b/%0d required %b/%0d", it, ffv_b, ffvec_b, first >= 0, first);
      end
    end
  endtask

  task automatic test_back_to_back();
    inv_a = 4'b0001;
    do_run(1'b0, 0);
    inv_a = '0;
    do_run(1'b0, 2);
    checks++; if (!seq_ok(NA)) begin errors++; $display("FAIL b2b_seq: got %0d vectors required 0..%0d in order", seq.size(), NA-1); end
    checks++; if (lat != NA + DEP + 1) begin errors++; $display("FAIL b2b_latency: got %0d required %0d", lat, NA + DEP + 1); end
    checks++;
    if (cnt_a !== 16'd0 || ffv_a !== 1'b0 || pass_a !== 1'b1) begin
      errors++; $display("FAIL b2b_clear: got cnt=%0d ffv=%b pass=%b required 0/0/1", cnt_a, ffv_a, pass_a);
    end
  endtask

  task automatic test_reset_mid_run();
    inv_a = '1;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({stim_a, sv_a, busy_a, done_a, pass_a, cnt_a, ffv_a, ffvec_a} !== '0) begin
      errors++; $display("FAIL midrst_zero: outputs %h required 0", {stim_a, sv_a, busy_a, done_a, pass_a, cnt_a, ffv_a, ffvec_a});
    end
    @(negedge clk) rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (cnt_a !== 16'd0 || ffv_a !== 1'b0 || done_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL midrst_stale: got cnt=%0d ffv=%b done=%b busy=%b required all 0", cnt_a, ffv_a, done_a, busy_a);
    end
    inv_a = '0;
    do_run(1'b0, 0);
    checks++; if (!seq_ok(NA) || lat != NA + DEP + 1) begin errors++; $display("FAIL midrst_rerun: got %0d vectors in %0d cycles required %0d in %0d", seq.size(), lat, NA, NA + DEP + 1); end
    checks++; if (pass_a !== 1'b1 || cnt_a !== 16'd0) begin errors++; $display("FAIL midrst_pass: got pass=%b cnt=%0d required 1/0", pass_a, cnt_a); end
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_single_fail();
    test_saturate();
    test_stop_on_fail();
    test_back_to_back();
    test_reset_mid_run();
    repeat (4) @(negedge clk);
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_equivalence_checker.md
Name: pipelined_equivalence_checker

Overview:
- Synthesizable on-chip counterpart to the simulation equivalence flow.
- Exhaustively drives every input vector into a test DUT and a ground-truth DUT, which sit outside this block and share one stimulus bus.
- Aligns both DUT outputs to the issued vector across a fixed pipeline depth, then compares them.
- Reports pass/fail, a mismatch count and the first failing vector; intended for FPGA bring-up of generated modules.

Parameters:
- IN_WIDTH, 2, total stimulus width (all DUT inputs concatenated); 1..20.
- OUT_WIDTH, 1, DUT output width.
- PIPELINE_DEPTH, 2, DUT latency in clock cycles; must be >= 1.
- CNT_WIDTH, 16, mismatch counter width.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle pulse that begins a run.
- stim_out  output  IN_WIDTH  vector driven to both DUTs.
- stim_valid  output  1  stim_out carries a vector under test.
- test_out  input  OUT_WIDTH  test DUT output.
- ground_truth_out  input  OUT_WIDTH  ground-truth DUT output.
- busy  output  1  run in progress.
- done  output  1  run complete; held until next start or rst.
- pass  output  1  valid while done; 1 iff mismatch_count==0.
- mismatch_count  output  CNT_WIDTH  compare failures; saturates at all-ones.
- first_fail_valid  output  1  first_fail_vector holds a captured vector.
- first_fail_vector  output  IN_WIDTH  vector of the earliest mismatch.

Behaviour:
- Reset (async assert, sync release internally):
  - state=IDLE.
  - All outputs 0: stim_out, stim_valid, busy, done, pass, mismatch_count, first_fail_valid, first_fail_vector.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 -> RUN.
  - Clear mismatch_count, first_fail_*, done, pass.
  - Vector index = 0.
- RUN:
  - Cycle k after start was sampled (k = 0..2^IN_WIDTH-1): stim_out=k, stim_valid=1.
  - Index increments by 1 each cycle.
  - After issuing vector 2^IN_WIDTH-1 -> DRAIN.
  - The index counter is IN_WIDTH+1 bits so the terminal vector is detected without wrap ambiguity.
- DRAIN:
  - stim_valid=0, stim_out holds the last vector.
  - Lasts exactly PIPELINE_DEPTH cycles -> DONE.
- Alignment:
  - Shift register of depth PIPELINE_DEPTH carries {valid, vector}.
  - On a cycle where the delayed valid is 1, sample test_out and ground_truth_out at that clock edge and compare all OUT_WIDTH bits.
  - Vector k is compared at the edge ending cycle k+PIPELINE_DEPTH.
- Mismatch:
  - mismatch_count += 1, saturating.
  - If first_fail_valid==0: first_fail_vector = delayed vector, first_fail_valid = 1.
  - Later mismatches never overwrite the captured vector.
- DONE:
  - done=1, busy=0.
  - pass = (mismatch_count==0).
  - start=1 -> full clear and new run, identical to start from IDLE.
- busy=1 in RUN and DRAIN only.
- Latency:
  - done rises 2^IN_WIDTH + PIPELINE_DEPTH + 1 cycles after the start edge.
  - Example: IN_WIDTH=2, depth 2 -> 7 cycles.
- start while busy is ignored; no restart and no counter effect.
- rst mid-run: immediate return to IDLE with all outputs zero; the alignment pipe is flushed, so no stale compare occurs after release.
- The DUTs themselves are not reset by this block.

Optional Feature:
- Macro: EQCHK_STOP_ON_FIRST_FAIL_EN.
- Defined:
  - First mismatch in RUN -> stop issuing new vectors.
  - stim_valid=0 from the next cycle; go to DRAIN and run a full PIPELINE_DEPTH cycles.
  - In-flight vectors are still compared and counted, so mismatch_count may exceed 1.
  - done rises early.
  - A mismatch first detected in DRAIN changes nothing.
- Undefined: every vector is always issued, as described in Behaviour.

Test Plan:
- IN_WIDTH=2, depth 2, both DUTs = registered 2-stage a&b, start pulse -> stim_out 0,1,2,3 with stim_valid=1 for 4 cycles; done=1 seven cycles after start; pass=1; mismatch_count=0; first_fail_valid=0.
- Same setup, ground truth outputs inverted only for vector 3 -> mismatch_count=1, first_fail_vector=3, first_fail_valid=1, pass=0.
- IN_WIDTH=3, CNT_WIDTH=2, ground truth always inverted -> mismatch_count saturates at 3, first_fail_vector=0, pass=0.
- Assert rst at cycle 2 of RUN, release, then start again with matching DUTs -> all outputs 0 during rst; second run passes with mismatch_count=0.
- Pulse start again in cycle 1 of RUN -> ignored; vector sequence and done timing unchanged; start in DONE -> clean rerun.
- EQCHK_STOP_ON_FIRST_FAIL_EN defined, IN_WIDTH=3, depth 2, mismatch on vector 1 only:
  - stim_valid drops after vector 3 is issued.
  - done asserts well before 11 cycles.
  - mismatch_count=1, first_fail_vector=1.
